// File: rtl/pwr_seq_if.sv
// Handshake bundle between the bias-chain sequencer and its surroundings.
// The slave side is the sequencer; the master side is whatever drives the
// power-up request and the analog ready flags (the bench, or top-level glue).
interface pwr_seq_if;
    logic       EN;
    logic       RDY_IREF;
    logic       RDY_LDO;
    logic       PU_IREF;
    logic       CAL_IREF;
    logic       PU_LDO;
    logic       RDY;
    logic       ERR;
    logic [2:0] STATE;

    modport master (
        output EN, RDY_IREF, RDY_LDO,
        input  PU_IREF, CAL_IREF, PU_LDO, RDY, ERR, STATE
    );

    modport slave (
        input  EN, RDY_IREF, RDY_LDO,
        output PU_IREF, CAL_IREF, PU_LDO, RDY, ERR, STATE
    );
endinterface

// File: rtl/pwr_seq.sv
// Power-up sequencer for the analog bias chain: current reference first
// (with a calibration hold), then the LDO, then system-ready. Timeouts and
// brown-outs latch a sticky error; dropping EN powers down in reverse order.
// A single down-counter is shared by every timed phase; it is only ever
// decremented while non-zero, so it cannot wrap.
module pwr_seq #(
    parameter int CAL_CYCLES = 8,
    parameter int TMO_IREF   = 64,
    parameter int TMO_LDO    = 32,
    parameter int PD_GAP     = 4,
    parameter int CNT_W      = 8
) (
    input  logic     CLK,
    input  logic     RST_N,
    pwr_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_OFF       = 3'd0,
        S_IREF_CAL  = 3'd1,
        S_IREF_WAIT = 3'd2,
        S_LDO_WAIT  = 3'd3,
        S_ON        = 3'd4,
        S_PD        = 3'd5,
        S_ERROR     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CAL_LOAD  = CNT_W'(CAL_CYCLES - 1);
    localparam logic [CNT_W-1:0] IREF_LOAD = CNT_W'(TMO_IREF - 1);
    localparam logic [CNT_W-1:0] LDO_LOAD  = CNT_W'(TMO_LDO - 1);
    localparam logic [CNT_W-1:0] PD_LOAD   = CNT_W'(PD_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pu_iref_q, pu_iref_d;
    logic             cal_iref_q, cal_iref_d;
    logic             pu_ldo_q, pu_ldo_d;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;

    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_zero = (cnt_q == CNT_ZERO);
    assign cnt_dec  = cnt_q - CNT_ONE;

    // Next-state and next-output decode; EN=0 is tested first in every
    // active state so a power-down request beats ready/timeout/brown-out.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pu_iref_d  = pu_iref_q;
        cal_iref_d = cal_iref_q;
        pu_ldo_d   = pu_ldo_q;
        rdy_d      = rdy_q;
        err_d      = err_q;

        case (state_q)
            S_OFF: begin
                if (bus.EN) begin
                    state_d    = S_IREF_CAL;
                    pu_iref_d  = 1'b1;
                    cal_iref_d = 1'b1;
                    cnt_d      = CAL_LOAD;
                end
            end

            S_IREF_CAL: begin
                if (!bus.EN) begin
                    state_d    = S_PD;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    cnt_d      = PD_LOAD;
                end else if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else begin
                    state_d    = S_IREF_WAIT;
                    cal_iref_d = 1'b0;
                    cnt_d      = IREF_LOAD;
                end
            end

            S_IREF_WAIT: begin
                if (!bus.EN) begin
                    state_d    = S_PD;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    cnt_d      = PD_LOAD;
                end else if (bus.RDY_IREF) begin
                    state_d  = S_LDO_WAIT;
                    pu_ldo_d = 1'b1;
                    cnt_d    = LDO_LOAD;
                end else if (cnt_zero) begin
                    state_d    = S_ERROR;
                    pu_iref_d  = 1'b0;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            S_LDO_WAIT: begin
                if (!bus.EN) begin
                    state_d    = S_PD;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    cnt_d      = PD_LOAD;
                end else if (bus.RDY_LDO) begin
                    state_d = S_ON;
                    rdy_d   = 1'b1;
                end else if (cnt_zero) begin
                    state_d    = S_ERROR;
                    pu_iref_d  = 1'b0;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            S_ON: begin
                if (!bus.EN) begin
                    state_d    = S_PD;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    cnt_d      = PD_LOAD;
                end else if (!bus.RDY_IREF || !bus.RDY_LDO) begin
                    state_d    = S_ERROR;
                    pu_iref_d  = 1'b0;
                    cal_iref_d = 1'b0;
                    pu_ldo_d   = 1'b0;
                    rdy_d      = 1'b0;
                    err_d      = 1'b1;
                end
            end

            S_PD: begin
                // EN is deliberately ignored until the reference is off.
                cal_iref_d = 1'b0;
                pu_ldo_d   = 1'b0;
                rdy_d      = 1'b0;
                if (!cnt_zero) begin
                    cnt_d = cnt_dec;
                end else begin
                    state_d   = S_OFF;
                    pu_iref_d = 1'b0;
                end
            end

            S_ERROR: begin
                pu_iref_d  = 1'b0;
                cal_iref_d = 1'b0;
                pu_ldo_d   = 1'b0;
                rdy_d      = 1'b0;
                err_d      = 1'b1;
                if (!bus.EN) begin
                    state_d = S_OFF;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d    = S_OFF;
                cnt_d      = CNT_ZERO;
                pu_iref_d  = 1'b0;
                cal_iref_d = 1'b0;
                pu_ldo_d   = 1'b0;
                rdy_d      = 1'b0;
                err_d      = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops everything at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_OFF;
            cnt_q      <= CNT_ZERO;
            pu_iref_q  <= 1'b0;
            cal_iref_q <= 1'b0;
            pu_ldo_q   <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pu_iref_q  <= pu_iref_d;
            cal_iref_q <= cal_iref_d;
            pu_ldo_q   <= pu_ldo_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    assign bus.PU_IREF  = pu_iref_q;
    assign bus.CAL_IREF = cal_iref_q;
    assign bus.PU_LDO   = pu_ldo_q;
    assign bus.RDY      = rdy_q;
    assign bus.ERR      = err_q;
    assign bus.STATE    = state_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Bench for pwr_seq: directed scenarios followed by randomized sessions.
// The reference model tracks the chain phase and absolute deadline edges;
// expected outputs are derived from which phase the chain is in.
module tb_pwr_seq;

    localparam int CAL_CYCLES = 8;
    localparam int TMO_IREF   = 64;
    localparam int TMO_LDO    = 32;
    localparam int PD_GAP     = 4;
    localparam int CNT_W      = 8;

    // model phases, numbered as the required STATE debug code
    localparam int M_OFF = 0, M_CAL = 1, M_WI = 2, M_WL = 3, M_ON = 4, M_PD = 5, M_ERR = 6;

    logic CLK;
    logic RST_N;
    pwr_seq_if bus ();

    pwr_seq #(
        .CAL_CYCLES (CAL_CYCLES),
        .TMO_IREF   (TMO_IREF),
        .TMO_LDO    (TMO_LDO),
        .PD_GAP     (PD_GAP),
        .CNT_W      (CNT_W)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // reference model
    int m_ph = M_OFF;
    int m_end = 0;

    // analog device models: cycles since each block became eligible
    int ic = 0, lc = 0;
    int iref_dly = 21, ldo_dly = 5;
    logic tie_ri0 = 1'b0, tie_rl0 = 1'b0;
    int ri_once = -1, rl_once = -1;

    // edge timestamps (edge index at which an output changed)
    int t_cal_rise, t_cal_fall, t_ldo_rise, t_rdy_rise, t_err_rise;
    logic p_cal = 1'b0, p_ldo = 1'b0, p_rdy = 1'b0, p_err = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cyc=%0d %s: got 0x%0h want 0x%0h", cyc, name, act, exp);
        end
    endtask

    function automatic int act_vec();
        return int'({bus.PU_IREF, bus.CAL_IREF, bus.PU_LDO, bus.RDY, bus.ERR, bus.STATE});
    endfunction

    function automatic int exp_vec();
        logic pu_i, cal, pu_l, rdy, err;
        pu_i = (m_ph == M_CAL) || (m_ph == M_WI) || (m_ph == M_WL) || (m_ph == M_ON) || (m_ph == M_PD);
        cal  = (m_ph == M_CAL);
        pu_l = (m_ph == M_WL) || (m_ph == M_ON);
        rdy  = (m_ph == M_ON);
        err  = (m_ph == M_ERR);
        return int'({pu_i, cal, pu_l, rdy, err, 3'(m_ph)});
    endfunction

    // Advance the model across edge number cyc+1 given the sampled inputs.
    task automatic model_edge(input logic en, input logic ri, input logic rl);
        int n;
        n = cyc + 1;
        case (m_ph)
            M_OFF: if (en) begin m_ph = M_CAL; m_end = n + CAL_CYCLES; end
            M_CAL: begin
                if (!en) begin m_ph = M_PD; m_end = n + PD_GAP; end
                else if (n == m_end) begin m_ph = M_WI; m_end = n + TMO_IREF; end
            end
            M_WI: begin
                if (!en) begin m_ph = M_PD; m_end = n + PD_GAP; end
                else if (ri) begin m_ph = M_WL; m_end = n + TMO_LDO; end
                else if (n == m_end) m_ph = M_ERR;
            end
            M_WL: begin
                if (!en) begin m_ph = M_PD; m_end = n + PD_GAP; end
                else if (rl) m_ph = M_ON;
                else if (n == m_end) m_ph = M_ERR;
            end
            M_ON: begin
                if (!en) begin m_ph = M_PD; m_end = n + PD_GAP; end
                else if (!ri || !rl) m_ph = M_ERR;
            end
            M_PD:  if (n == m_end) m_ph = M_OFF;
            M_ERR: if (!en) m_ph = M_OFF;
            default: m_ph = M_OFF;
        endcase
    endtask

    task automatic clear_marks();
        t_cal_rise = -1000; t_cal_fall = -1000; t_ldo_rise = -1000;
        t_rdy_rise = -1000; t_err_rise = -1000;
    endtask

    task automatic observe();
        ic = (bus.PU_IREF && !bus.CAL_IREF) ? ic + 1 : 0;
        lc = bus.PU_LDO ? lc + 1 : 0;
        if (bus.CAL_IREF && !p_cal) t_cal_rise = cyc;
        if (!bus.CAL_IREF && p_cal) t_cal_fall = cyc;
        if (bus.PU_LDO && !p_ldo)   t_ldo_rise = cyc;
        if (bus.RDY && !p_rdy)      t_rdy_rise = cyc;
        if (bus.ERR && !p_err)      t_err_rise = cyc;
        p_cal = bus.CAL_IREF; p_ldo = bus.PU_LDO; p_rdy = bus.RDY; p_err = bus.ERR;
    endtask

    // One clock: drive inputs (called at a falling edge), advance the model,
    // then compare at the next falling edge.
    task automatic step(input logic en);
        logic ri, rl;
        ri = !tie_ri0 && (ic >= iref_dly + 1);
        if (ri_once >= 0) ri = (ri_once != 0);
        rl = !tie_rl0 && (lc >= ldo_dly + 1);
        if (rl_once >= 0) rl = (rl_once != 0);
        ri_once = -1;
        rl_once = -1;
        bus.EN = en;
        bus.RDY_IREF = ri;
        bus.RDY_LDO = rl;
        model_edge(en, ri, rl);
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
        observe();
        chk("outputs", act_vec(), exp_vec());
        $display("cyc=%0d en=%0b ri=%0b rl=%0b state=%0d pu_iref=%0b cal=%0b pu_ldo=%0b rdy=%0b err=%0b",
                 cyc, en, ri, rl, bus.STATE, bus.PU_IREF, bus.CAL_IREF, bus.PU_LDO, bus.RDY, bus.ERR);
    endtask

    task automatic power_off();
        for (int i = 0; i < 8; i++) step(1'b0);
    endtask

    int start;
    logic en_r;

    initial begin
        RST_N = 1'b0;
        bus.EN = 1'b0;
        bus.RDY_IREF = 1'b0;
        bus.RDY_LDO = 1'b0;
        clear_marks();
        #3;
        chk("reset_outputs", act_vec(), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        observe();

        // normal power-up
        clear_marks();
        iref_dly = 21; ldo_dly = 5;
        start = cyc;
        for (int i = 0; i < 100 && !bus.RDY; i++) step(1'b1);
        chk("pu_latency", t_cal_rise - start, 1);
        chk("cal_width", t_cal_fall - t_cal_rise, 8);
        chk("ldo_after_cal", t_ldo_rise - t_cal_fall, 22);
        chk("rdy_after_ldo", t_rdy_rise - t_ldo_rise, 6);
        chk("normal_err", int'(bus.ERR), 0);

        // ordered power-down, EN re-raised during PD is ignored
        step(1'b0);
        chk("pd_first", int'({bus.PU_IREF, bus.PU_LDO, bus.RDY, bus.STATE}), int'({1'b1, 1'b0, 1'b0, 3'd5}));
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("pd_hold", int'({bus.PU_IREF, bus.STATE}), int'({1'b1, 3'd5}));
        step(1'b1);
        chk("pd_done", int'({bus.PU_IREF, bus.STATE}), 0);
        step(1'b0);

        // brown-out in ON
        for (int i = 0; i < 100 && !bus.RDY; i++) step(1'b1);
        step(1'b1); step(1'b1);
        rl_once = 0;
        step(1'b1);
        chk("brownout", act_vec(), int'({5'b00001, 3'd6}));
        for (int i = 0; i < 3; i++) step(1'b1);
        chk("brownout_sticky", int'({bus.ERR, bus.STATE}), int'({1'b1, 3'd6}));
        step(1'b0);
        chk("err_clear", int'({bus.ERR, bus.STATE}), 0);

        // IREF timeout
        clear_marks();
        tie_ri0 = 1'b1;
        for (int i = 0; i < 200 && !bus.ERR; i++) step(1'b1);
        chk("iref_tmo_edges", t_err_rise - t_cal_fall, 64);
        chk("iref_tmo_outs", int'({bus.PU_IREF, bus.STATE}), int'({1'b0, 3'd6}));
        step(1'b0);
        chk("tmo_clear", int'({bus.ERR, bus.STATE}), 0);

        // EN drop and RDY_IREF rise together in IREF_WAIT
        for (int i = 0; i < 12; i++) step(1'b1);
        ri_once = 1;
        step(1'b0);
        chk("simul_pd", int'({bus.PU_LDO, bus.STATE}), int'({1'b0, 3'd5}));
        tie_ri0 = 1'b0;
        power_off();

        // LDO ready on the very last timeout cycle
        clear_marks();
        iref_dly = 21; ldo_dly = 31;
        for (int i = 0; i < 200 && !bus.RDY && !bus.ERR; i++) step(1'b1);
        chk("ldo_last_cycle", int'({bus.ERR, bus.STATE}), int'({1'b0, 3'd4}));
        chk("ldo_last_edges", t_rdy_rise - t_ldo_rise, 32);
        power_off();

        // asynchronous reset in LDO_WAIT, off-edge, EN held high
        tie_rl0 = 1'b1;
        for (int i = 0; i < 100 && !bus.PU_LDO; i++) step(1'b1);
        for (int i = 0; i < 3; i++) step(1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset", act_vec(), 0);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        cyc++;
        m_ph = M_OFF;
        ic = 0; lc = 0;
        observe();
        chk("reset_held", act_vec(), exp_vec());
        tie_rl0 = 1'b0;
        step(1'b1);
        chk("restart", int'({bus.CAL_IREF, bus.STATE}), int'({1'b1, 3'd1}));
        power_off();

        // randomized sessions
        en_r = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (!bus.PU_IREF) begin
                iref_dly = $urandom_range(0, 70);
                ldo_dly  = $urandom_range(0, 36);
            end
            if (en_r) begin
                if ($urandom_range(0, 149) == 0) en_r = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                en_r = 1'b1;
            end
            if (bus.RDY && $urandom_range(0, 79) == 0) begin
                if ($urandom_range(0, 1) == 0) rl_once = 0;
                else ri_once = 0;
            end
            step(en_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwr_seq.md
# pwr_seq

Power-up sequencer for the analog bias chain. Drives the current-reference block's `PU_IREF`/`CAL_IREF` inputs and consumes its `RDY_IREF`. Once the reference is ready, it powers up the downstream LDO and consumes `RDY_LDO`. It reports system-ready, or a sticky error on timeout or brown-out, and powers down in reverse order.

## Interface
- `CAL_CYCLES`, default 8: cycles `CAL_IREF` is held high after `PU_IREF` rises (≥1).
- `TMO_IREF`, default 64: cycles allowed for `RDY_IREF` after `CAL_IREF` falls (≥1).
- `TMO_LDO`, default 32: cycles allowed for `RDY_LDO` after `PU_LDO` rises (≥1).
- `PD_GAP`, default 4: cycles between `PU_LDO` falling and `PU_IREF` falling (≥1).
- `CNT_W`, default 8: width of the shared down-counter; must hold max(all above)−1.
- `CLK`, input, 1: single clock, all logic on rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `EN`, input, 1: power-up request; level-sensitive.
- `RDY_IREF`, input, 1: ready from the current reference.
- `RDY_LDO`, input, 1: ready from the LDO.
- `PU_IREF`, output, 1: current-reference power-up.
- `CAL_IREF`, output, 1: current-reference calibration hold.
- `PU_LDO`, output, 1: LDO power-up.
- `RDY`, output, 1: whole chain up.
- `ERR`, output, 1: sticky fault flag.
- `STATE`, output, 3: current state encoding, for debug.

## Operation
- All outputs are registered. Reset forces state OFF, counter 0, and every output 0, immediately and asynchronously.
- State encodings: OFF=0, IREF_CAL=1, IREF_WAIT=2, LDO_WAIT=3, ON=4, PD=5, ERROR=6.
- **OFF:** `EN`=1 → IREF_CAL; set `PU_IREF`=1, `CAL_IREF`=1, cnt=`CAL_CYCLES`−1.
- **IREF_CAL:** cnt≠0 → decrement. cnt=0 → IREF_WAIT; set `CAL_IREF`=0, cnt=`TMO_IREF`−1.
- **IREF_WAIT:** `RDY_IREF`=1 → LDO_WAIT; set `PU_LDO`=1, cnt=`TMO_LDO`−1. Otherwise cnt=0 → ERROR; otherwise decrement.
- **LDO_WAIT:** `RDY_LDO`=1 → ON; set `RDY`=1. Otherwise cnt=0 → ERROR; otherwise decrement.
- **ON:** `RDY_IREF`=0 or `RDY_LDO`=0 → ERROR (brown-out).
- **PD:** `PU_LDO`=0, `CAL_IREF`=0, `RDY`=0. cnt≠0 → decrement. cnt=0 → OFF; set `PU_IREF`=0. `EN` is ignored in PD.
- **ERROR:** all PU/CAL outputs and `RDY` are 0; `ERR`=1. `EN`=0 → OFF, with `ERR` cleared on that edge.
- **`EN`=0 handling:**
  - In IREF_CAL, IREF_WAIT, LDO_WAIT or ON: → PD with cnt=`PD_GAP`−1.
  - This has priority over any ready, timeout or brown-out event in the same cycle.
- **`EN`=1 in OFF after ERROR:** restarts the sequence normally.
- **Counter:** unsigned `CNT_W` bits. It never wraps because it is only decremented when non-zero.

## Timing
- `PU_IREF` and `CAL_IREF` rise 1 edge after `EN` is sampled high in OFF.
- `CAL_IREF` is high for exactly `CAL_CYCLES` cycles.
- **Timeout, IREF:** ERROR entered on the `TMO_IREF`-th edge after `CAL_IREF` falls, if `RDY_IREF` is never sampled high.
- **Timeout, LDO:** ERROR entered on the `TMO_LDO`-th edge after `PU_LDO` rises, if `RDY_LDO` is never sampled high.
- Ready sampled on the final timeout cycle counts as success; the ready check has priority over timeout.
- `PU_LDO` rises 1 edge after `RDY_IREF` is sampled high.
- `RDY` rises 1 edge after `RDY_LDO` is sampled high.
- **Power-down:** `PU_LDO` and `RDY` fall 1 edge after `EN` is sampled low. `PU_IREF` falls `PD_GAP` edges after that.
- **Brown-out:** `ERR` rises and all PU outputs fall 1 edge after the drop is sampled.

## Test plan
Defaults for all cases; current-reference model asserts `RDY_IREF` 21 cycles after `CAL_IREF` falls.

- **Normal power-up:** `EN`↑ with LDO model ready 5 cycles after `PU_LDO`↑. Expect `CAL_IREF` high 8 cycles, `PU_LDO` 22 edges after `CAL_IREF`↓, `RDY` 6 edges after `PU_LDO`↑, `ERR`=0.
- **IREF timeout:** `RDY_IREF` tied 0. Expect `ERR`=1, `PU_IREF`=0, `STATE`=6 exactly 64 edges after `CAL_IREF`↓. Then `EN`↓ → `ERR`=0, `STATE`=0 next edge.
- **Ordered power-down:** `EN`↓ in ON. Expect `PU_LDO`=0 and `RDY`=0 next edge, `PU_IREF`=0 four edges later, and `EN`↑ during PD ignored.
- **Brown-out:** `RDY_LDO` pulled low for 1 cycle in ON. Expect `ERR`=1 and `PU_IREF`/`PU_LDO`/`RDY`=0 next edge, held until `EN`↓.
- **Simultaneous events:** in IREF_WAIT, `EN`↓ on the same cycle `RDY_IREF`↑. Expect `STATE`=5 and `PU_LDO` stays 0. In LDO_WAIT on the last timeout cycle with `RDY_LDO`↑, expect ON, not ERROR.
- **Reset mid-operation:** `RST_N`↓ in LDO_WAIT, off-edge. Expect all outputs 0 immediately, `STATE`=0. After release with `EN` held 1, the sequence restarts from IREF_CAL.
